// File: rtl/hall98_fetch.sv
// Instruction fetch/decode stage for the hall98 core: reads ROM words, unpacks them into opcode/re/n, and holds each for HOLD_CYCLES.
// Optional illegal-opcode trap enabled by defining HALL98_FETCH_ILLEGAL_TRAP_EN.
module hall98_fetch #(
  parameter int         PROG_DEPTH  = 64,
  parameter int         AW          = 6,
  parameter int         HOLD_CYCLES = 50,
  parameter logic [7:0] HALT_OP     = 8'h00
) (
  input  logic          iclock,
  input  logic          reset,
  input  logic          start,
  output logic [AW-1:0] mem_addr,
  input  logic [31:0]   mem_rdata,
  output logic [31:0]   opcode,
  output logic [31:0]   re,
  output logic [31:0]   n,
  output logic          flag,
  output logic          busy,
  output logic [AW-1:0] pc,
  output logic          err
);

  localparam int CW = $clog2(HOLD_CYCLES) + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_LATCH,
    S_ISSUE,
    S_DONE
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;

  logic [CW-1:0] r_cnt;
  logic [AW-1:0] r_pc;
  logic [AW-1:0] r_mem_addr;
  logic [7:0]    r_op;
  logic [7:0]    r_re;
  logic [15:0]   r_n;
  logic          r_flag;
  logic          r_busy;
  logic          r_err;

  logic [7:0]    w_word_op;
  logic          w_is_halt;
  logic          w_illegal;
  logic          w_last_pc;
  logic          w_hold_done;
  logic          w_start_run;
  logic          w_issue;
  logic          w_trap;
  logic          w_advance;

  assign w_word_op   = mem_rdata[7:0];
  assign w_is_halt   = (w_word_op == HALT_OP);
  assign w_last_pc   = (r_pc == AW'(PROG_DEPTH - 1));
  assign w_hold_done = (r_cnt == '0);

`ifdef HALL98_FETCH_ILLEGAL_TRAP_EN
  // Legal set is the halt byte plus the contiguous core opcode range 0x45..0x4A.
  assign w_illegal = !w_is_halt && !((w_word_op >= 8'h45) && (w_word_op <= 8'h4A));
`else
  assign w_illegal = 1'b0;
`endif

  always_ff @(posedge iclock or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_start_run = 1'b0;
    w_issue     = 1'b0;
    w_trap      = 1'b0;
    w_advance   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_nxt = S_FETCH;
          w_start_run = 1'b1;
        end
      end
      S_FETCH: begin
        w_state_nxt = S_LATCH;
      end
      S_LATCH: begin
        if (w_is_halt) begin
          w_state_nxt = S_DONE;
        end else if (w_illegal) begin
          w_state_nxt = S_DONE;
          w_trap      = 1'b1;
        end else begin
          w_state_nxt = S_ISSUE;
          w_issue     = 1'b1;
        end
      end
      S_ISSUE: begin
        if (w_hold_done) begin
          if (w_last_pc) begin
            w_state_nxt = S_DONE;
          end else begin
            w_state_nxt = S_FETCH;
            w_advance   = 1'b1;
          end
        end
      end
      S_DONE: begin
        if (start) begin
          w_state_nxt = S_FETCH;
          w_start_run = 1'b1;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Address is registered on the edge entering FETCH so the ROM sees it for the whole FETCH cycle.
  always_ff @(posedge iclock or posedge reset) begin
    if (reset) begin
      r_pc       <= '0;
      r_mem_addr <= '0;
    end else if (w_start_run) begin
      r_pc       <= '0;
      r_mem_addr <= '0;
    end else if (w_advance) begin
      r_pc       <= r_pc + 1'b1;
      r_mem_addr <= r_pc + 1'b1;
    end
  end

  always_ff @(posedge iclock or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (w_issue) begin
      r_cnt <= CW'(HOLD_CYCLES - 1);
    end else if ((r_state == S_ISSUE) && !w_hold_done) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  // opcode is live only while in ISSUE; re/n keep their last values for the core.
  always_ff @(posedge iclock or posedge reset) begin
    if (reset) begin
      r_op <= '0;
      r_re <= '0;
      r_n  <= '0;
    end else if (w_issue) begin
      r_op <= mem_rdata[7:0];
      r_re <= mem_rdata[15:8];
      r_n  <= mem_rdata[31:16];
    end else if (w_state_nxt != S_ISSUE) begin
      r_op <= '0;
    end
  end

  always_ff @(posedge iclock or posedge reset) begin
    if (reset) begin
      r_flag <= 1'b0;
      r_busy <= 1'b0;
      r_err  <= 1'b0;
    end else begin
      r_flag <= (w_state_nxt == S_DONE);
      r_busy <= (w_state_nxt == S_FETCH) || (w_state_nxt == S_LATCH) ||
                (w_state_nxt == S_ISSUE);
      if (w_start_run) begin
        r_err <= 1'b0;
      end else if (w_trap) begin
        r_err <= 1'b1;
      end
    end
  end

  assign mem_addr = r_mem_addr;
  assign pc       = r_pc;
  assign opcode   = {24'b0, r_op};
  assign re       = {24'b0, r_re};
  assign n        = {16'b0, r_n};
  assign flag     = r_flag;
  assign busy     = r_busy;
  assign err      = r_err;

endmodule
